// File: rtl/picobello_link_stage.sv
// Elastic valid/ready FIFO stage for one NoC mesh link channel; outputs come only from flops.
// Optional traffic counters are built when PICOBELLO_LINK_STATS_EN is defined.

module picobello_link_stage #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 2,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [CntWidth-1:0]  occupancy_o,
    input  logic                 stat_clr_i,
    output logic [31:0]          stat_flits_o,
    output logic [31:0]          stat_stalls_o
);

    localparam int unsigned         PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] PtrMax   = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] CntFull  = CntWidth'(Depth);

    // Sized to the full pointer range so a 1-deep stage still has a legal 1-bit index.
    logic [DataWidth-1:0] mem_q [2**PtrWidth];
    logic [PtrWidth-1:0]  wptr_q, wptr_d;
    logic [PtrWidth-1:0]  rptr_q, rptr_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 push;
    logic                 pop;

    // Handshake: a flit moves across an interface at a rising edge where valid and ready
    // are both high. valid_o/data_o and ready_o depend only on state (plus rst_ni gating
    // ready_o), so neither side ever sees a combinational path through this stage.
    assign ready_o     = rst_ni && (cnt_q != CntFull);
    assign valid_o     = (cnt_q != '0);
    assign push        = valid_i && ready_o;
    assign pop         = valid_o && ready_i;
    assign data_o      = mem_q[rptr_q];
    assign occupancy_o = cnt_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            wptr_d = (wptr_q == PtrMax) ? '0 : wptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrMax) ? '0 : rptr_q + PtrWidth'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage carries no reset; stale contents are never presented while cnt is 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

`ifdef PICOBELLO_LINK_STATS_EN
    logic [31:0] stat_flits_q, stat_flits_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;
    logic        stall;

    assign stall = valid_o && !ready_i;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        stat_flits_d  = stat_flits_q;
        stat_stalls_d = stat_stalls_q;
        if (stat_clr_i) begin
            stat_flits_d  = '0;
            stat_stalls_d = '0;
        end else begin
            if (pop && (stat_flits_q != 32'hFFFF_FFFF)) begin
                stat_flits_d = stat_flits_q + 32'd1;
            end
            if (stall && (stat_stalls_q != 32'hFFFF_FFFF)) begin
                stat_stalls_d = stat_stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_flits_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_flits_q  <= stat_flits_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_flits_o  = stat_flits_q;
    assign stat_stalls_o = stat_stalls_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr_i;
    assign stat_flits_o    = '0;
    assign stat_stalls_o   = '0;
`endif

endmodule
